// File: rtl/kamikaze_instr_aligner_if.sv
// Fetch bus, redirect and instruction-issue signals of the realignment buffer.
// master = aligner side; slave = fetch memory / decoder side.
interface kamikaze_instr_aligner_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i;
  logic        fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;

  modport master (
    input  flush_i, flush_pc_i, fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i, instr_ready_i,
    output fetch_req_o, fetch_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_compressed_o
  );

  modport slave (
    output flush_i, flush_pc_i, fetch_gnt_i, fetch_rvalid_i, fetch_rdata_i, instr_ready_i,
    input  fetch_req_o, fetch_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_compressed_o
  );
endinterface

// File: rtl/kamikaze_instr_aligner.sv
// Fetch realignment buffer: word fetches in, halfword-aligned instructions out.
// Define ALIGNER_RVC_EN to enable 16-bit parcels and straddling 32-bit instructions.
module kamikaze_instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic clk_i,
  input logic rst_i,
  kamikaze_instr_aligner_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam logic [AW+1:0] SUM_DEPTH = (AW+2)'(DEPTH);

`ifdef ALIGNER_RVC_EN
  localparam logic RESET_OFFSET = RESET_PC[1];
`else
  localparam logic RESET_OFFSET = 1'b0;
`endif
  localparam logic [31:0] RESET_IPC = {RESET_PC[31:2], RESET_OFFSET, 1'b0};

  logic [31:0] mem [DEPTH];
  ptr_t        rd_ptr, wr_ptr;
  cnt_t        count, outstanding, discard;
  logic        offset;
  logic [31:0] instr_pc, fetch_addr;

  logic [31:0] head, instr;
  logic        is_rvc, have_instr, valid, consume, pop, push, req, flush_offset;
  logic [31:0] flush_ipc;

  assign head = mem[rd_ptr];

`ifdef ALIGNER_RVC_EN
  ptr_t        rd_next;
  logic [31:0] next_word;
  logic [15:0] parcel;
  logic        unused_flush_bits;

  assign rd_next           = rd_ptr + ptr_t'(1);
  assign next_word         = mem[rd_next];
  assign flush_offset      = bus.flush_pc_i[1];
  assign unused_flush_bits = bus.flush_pc_i[0];

  // A 32-bit instruction in the upper half straddles into the following word.
  always_comb begin
    parcel     = offset ? head[31:16] : head[15:0];
    is_rvc     = (parcel[1:0] != 2'b11);
    instr      = head;
    have_instr = (count != '0);
    if (is_rvc) begin
      instr = {16'h0000, parcel};
    end else if (offset) begin
      instr      = {next_word[15:0], head[31:16]};
      have_instr = (count >= cnt_t'(2));
    end
  end
`else
  logic unused_flush_bits;

  assign flush_offset      = 1'b0;
  assign unused_flush_bits = ^bus.flush_pc_i[1:0];
  assign is_rvc            = 1'b0;
  assign instr             = head;
  assign have_instr        = (count != '0);
`endif

  assign flush_ipc = {bus.flush_pc_i[31:2], flush_offset, 1'b0};
  assign req       = !rst_i && !bus.flush_i &&
                     (({1'b0, count} + {1'b0, outstanding}) < SUM_DEPTH);
  assign valid     = !rst_i && !bus.flush_i && have_instr;
  assign consume   = valid && bus.instr_ready_i;
  assign pop       = consume && (!is_rvc || offset);
  assign push      = bus.fetch_rvalid_i && (discard == '0) && !bus.flush_i;

  assign bus.fetch_req_o        = req;
  assign bus.fetch_addr_o       = fetch_addr;
  assign bus.instr_valid_o      = valid;
  assign bus.instr_o            = instr;
  assign bus.instr_pc_o         = instr_pc;
  assign bus.instr_compressed_o = is_rvc;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.fetch_rdata_i;
    end
  end

  // Responses still in flight at a redirect are counted into discard and dropped on return.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      offset      <= RESET_OFFSET;
      instr_pc    <= RESET_IPC;
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
    end else begin
      outstanding <= outstanding + cnt_t'(req && bus.fetch_gnt_i) - cnt_t'(bus.fetch_rvalid_i);
      if (bus.flush_i) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        discard    <= outstanding - cnt_t'(bus.fetch_rvalid_i);
        offset     <= flush_offset;
        instr_pc   <= flush_ipc;
        fetch_addr <= {bus.flush_pc_i[31:2], 2'b00};
      end else begin
        if (req && bus.fetch_gnt_i) begin
          fetch_addr <= fetch_addr + 32'd4;
        end
        if (bus.fetch_rvalid_i && (discard != '0)) begin
          discard <= discard - cnt_t'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + ptr_t'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
        count <= count + cnt_t'(push) - cnt_t'(pop);
        if (consume) begin
          offset   <= offset ^ is_rvc;
          instr_pc <= instr_pc + (is_rvc ? 32'd2 : 32'd4);
        end
      end
    end
  end
endmodule

// File: tb/tb_kamikaze_instr_aligner.sv
// Bench for kamikaze_instr_aligner: ideal in-order fetch memory, vector table plus corner sequences.
// Expected values follow the ALIGNER_RVC_EN setting the bench is compiled with.
module tb_kamikaze_instr_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kamikaze_instr_aligner_if bus();

  kamikaze_instr_aligner #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] flush_pc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] i0;
    logic [31:0] pc0;
    logic        c0;
    logic [31:0] i1;
    logic [31:0] pc1;
    logic        c1;
  } vec_t;

  localparam int NVEC = 6;
  localparam int UNLIMITED = 1000000;

  vec_t        vecs [NVEC];
  logic [31:0] memory [logic [31:0]];
  logic [31:0] pending [$];
  int          budget = UNLIMITED;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (memory.exists(a)) return memory[a];
    return 32'h0000_0013;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // One clock: record grant/response before the edge, present the next response after it.
  task automatic apply_stimulus();
    bit          granted;
    bit          responded;
    logic [31:0] addr;
    #1;
    granted   = bus.fetch_req_o && bus.fetch_gnt_i;
    responded = bus.fetch_rvalid_i;
    addr      = bus.fetch_addr_o;
    @(posedge clk);
    if (responded && pending.size() > 0) void'(pending.pop_front());
    if (granted) pending.push_back(addr);
    @(negedge clk);
    if (budget > 0 && pending.size() > 0) begin
      bus.fetch_rvalid_i = 1'b1;
      bus.fetch_rdata_i  = lookup(pending[0]);
      budget--;
    end else begin
      bus.fetch_rvalid_i = 1'b0;
      bus.fetch_rdata_i  = 32'h0;
    end
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.instr_valid_o && n < 60) begin
      apply_stimulus();
      n++;
    end
    check_output({name, "_valid"}, 32'(bus.instr_valid_o), 32'd1);
  endtask

  task automatic reset_dut();
    rst                = 1'b1;
    bus.flush_i        = 1'b0;
    bus.instr_ready_i  = 1'b0;
    bus.fetch_rvalid_i = 1'b0;
    budget             = UNLIMITED;
    pending.delete();
    #1;
    check_output("rst_req", 32'(bus.fetch_req_o), 32'd0);
    check_output("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    apply_stimulus();
    apply_stimulus();
    rst = 1'b0;
    #1;
  endtask

  task automatic pulse_flush(input logic [31:0] pc);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = pc;
    #1;
    check_output("flush_valid", 32'(bus.instr_valid_o), 32'd0);
    apply_stimulus();
    bus.flush_i = 1'b0;
  endtask

  task automatic check_instr(input string name, input logic [31:0] i, input logic [31:0] pc, input logic c);
    check_output({name, "_instr"}, bus.instr_o, i);
    check_output({name, "_pc"}, bus.instr_pc_o, pc);
    check_output({name, "_comp"}, 32'(bus.instr_compressed_o), 32'(c));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef ALIGNER_RVC_EN
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0093, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'h0000_0093, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h4501_4081, 32'h0000_0013, 32'h0000_4081, 32'h0000_0000, 1'b1, 32'h0000_4501, 32'h0000_0002, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0013_4081, 32'hAAAA_0000, 32'h0000_4081, 32'h0000_0000, 1'b1, 32'h0000_0013, 32'h0000_0002, 1'b0};
    vecs[3] = '{32'h0000_0102, 32'h8082_1234, 32'h0000_0013, 32'h0000_8082, 32'h0000_0102, 1'b1, 32'h0000_0013, 32'h0000_0104, 1'b0};
    vecs[4] = '{32'h0000_0002, 32'h0093_0000, 32'h1111_0000, 32'h0000_0093, 32'h0000_0002, 1'b0, 32'h0000_1111, 32'h0000_0006, 1'b1};
`else
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0093, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'h0000_0093, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h4501_4081, 32'h0000_0013, 32'h4501_4081, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0000_0004, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0013_4081, 32'hAAAA_0000, 32'h0013_4081, 32'h0000_0000, 1'b0, 32'hAAAA_0000, 32'h0000_0004, 1'b0};
    vecs[3] = '{32'h0000_0102, 32'h8082_1234, 32'h0000_0013, 32'h8082_1234, 32'h0000_0100, 1'b0, 32'h0000_0013, 32'h0000_0104, 1'b0};
    vecs[4] = '{32'h0000_0002, 32'h0093_0000, 32'h1111_0000, 32'h0093_0000, 32'h0000_0000, 1'b0, 32'h1111_0000, 32'h0000_0004, 1'b0};
`endif
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0093, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 32'h0000_0093, 32'h0000_0000, 1'b0};

    bus.flush_i        = 1'b0;
    bus.flush_pc_i     = 32'h0;
    bus.fetch_gnt_i    = 1'b1;
    bus.fetch_rvalid_i = 1'b0;
    bus.fetch_rdata_i  = 32'h0;
    bus.instr_ready_i  = 1'b0;

    // Reset state and first-response latency
    memory[32'h0] = 32'h0000_0013;
    memory[32'h4] = 32'h0000_0093;
    reset_dut();
    check_output("post_rst_req", 32'(bus.fetch_req_o), 32'd1);
    check_output("post_rst_addr", bus.fetch_addr_o, 32'h0);
    apply_stimulus();
    check_output("lat_rvalid_cycle", 32'(bus.instr_valid_o), 32'd0);
    apply_stimulus();
    check_output("lat_next_cycle", 32'(bus.instr_valid_o), 32'd1);
    check_instr("first", 32'h0000_0013, 32'h0, 1'b0);
    bus.instr_ready_i = 1'b1;
    apply_stimulus();
    bus.instr_ready_i = 1'b0;
    wait_valid("second");
    check_instr("second", 32'h0000_0093, 32'h4, 1'b0);

    // Table-driven redirects
    for (int k = 0; k < NVEC; k++) begin
      memory[{vecs[k].flush_pc[31:2], 2'b00}]          = vecs[k].w0;
      memory[{vecs[k].flush_pc[31:2], 2'b00} + 32'd4]  = vecs[k].w1;
      pulse_flush(vecs[k].flush_pc);
      wait_valid($sformatf("v%0d_i0", k));
      check_instr($sformatf("v%0d_i0", k), vecs[k].i0, vecs[k].pc0, vecs[k].c0);
      bus.instr_ready_i = 1'b1;
      apply_stimulus();
      bus.instr_ready_i = 1'b0;
      wait_valid($sformatf("v%0d_i1", k));
      check_instr($sformatf("v%0d_i1", k), vecs[k].i1, vecs[k].pc1, vecs[k].c1);
    end

    // Second word withheld: valid must stay low until it arrives
    memory[32'h0] = 32'h0013_4081;
    memory[32'h4] = 32'hAAAA_0000;
    reset_dut();
    budget = 1;
    wait_valid("hold_i0");
`ifdef ALIGNER_RVC_EN
    check_instr("hold_i0", 32'h0000_4081, 32'h0, 1'b1);
`else
    check_instr("hold_i0", 32'h0013_4081, 32'h0, 1'b0);
`endif
    bus.instr_ready_i = 1'b1;
    apply_stimulus();
    bus.instr_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) apply_stimulus();
    check_output("hold_low", 32'(bus.instr_valid_o), 32'd0);
    budget = UNLIMITED;
    wait_valid("hold_i1");
`ifdef ALIGNER_RVC_EN
    check_instr("hold_i1", 32'h0000_0013, 32'h2, 1'b0);
`else
    check_instr("hold_i1", 32'hAAAA_0000, 32'h4, 1'b0);
`endif

    // Downstream stall: buffer fills and fetching stops
    memory[32'h0] = 32'h0000_0013;
    memory[32'h4] = 32'h0000_0093;
    reset_dut();
    for (int n = 0; n < 10; n++) apply_stimulus();
    check_output("stall_req", 32'(bus.fetch_req_o), 32'd0);
    check_output("stall_addr", bus.fetch_addr_o, 32'h8);
    check_output("stall_valid", 32'(bus.instr_valid_o), 32'd1);
    check_output("stall_instr", bus.instr_o, 32'h0000_0013);

    // Redirect with two fetches outstanding: both responses dropped
    memory[32'h0]   = 32'h1111_1113;
    memory[32'h4]   = 32'h2222_2223;
    memory[32'h100] = 32'h8082_1234;
    memory[32'h104] = 32'h0000_0013;
    reset_dut();
    budget = 0;
    for (int n = 0; n < 3; n++) apply_stimulus();
    check_output("out2_req", 32'(bus.fetch_req_o), 32'd0);
    pulse_flush(32'h0000_0102);
    check_output("out2_addr", bus.fetch_addr_o, 32'h100);
    budget = UNLIMITED;
    wait_valid("out2");
`ifdef ALIGNER_RVC_EN
    check_instr("out2", 32'h0000_8082, 32'h102, 1'b1);
`else
    check_instr("out2", 32'h8082_1234, 32'h100, 1'b0);
`endif

    // Flush, response and ready all in one cycle
    memory[32'h0]   = 32'h0000_0013;
    memory[32'h4]   = 32'h0000_0093;
    memory[32'h200] = 32'h0000_0293;
    reset_dut();
    for (int n = 0; n < 20 && !(bus.instr_valid_o && bus.fetch_rvalid_i); n++) apply_stimulus();
    check_output("same_setup", 32'(bus.instr_valid_o && bus.fetch_rvalid_i), 32'd1);
    bus.instr_ready_i = 1'b1;
    pulse_flush(32'h0000_0200);
    bus.instr_ready_i = 1'b0;
    check_output("same_addr", bus.fetch_addr_o, 32'h200);
    wait_valid("same");
    check_instr("same", 32'h0000_0293, 32'h200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
